// File: rtl/traffic_pkg.sv
// ============================================================================
// traffic_pkg : shared timing constants and helpers for the traffic-light
//               controller and its countdown back-end.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    localparam int CNT_W_DEF  = 4;
    localparam int CLK_HZ_DEF = 50000000;
    localparam int SIM_CLK_HZ = 10;

    localparam int GO_TIME    = 8;
    localparam int WAIT_TIME  = 2;
    localparam int CROSS_TIME = 10;

    // Two-digit BCD (tens nibble, units nibble); valid for values below 100.
    function automatic logic [7:0] to_bcd8(input logic [7:0] v);
        return {4'(v / 8'd10), 4'(v % 8'd10)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_countdown_tick_gen.sv
// ============================================================================
// tick_gen : prescaler producing a one-cycle tick every CLK_HZ cycles of run.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_gen
    import traffic_pkg::*;
#(
    parameter int CLK_HZ = SIM_CLK_HZ
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick_1s
);

    localparam int              PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] C_LAST = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0] r_pre;
    logic             r_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else if (!run) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else if (r_pre == C_LAST) begin
            r_pre  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_pre  <= r_pre + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign tick_1s = r_tick;

endmodule

`default_nettype wire

// File: rtl/traffic_countdown.sv
// ============================================================================
// traffic_countdown : 1 s tick plus pd / nopd phase down-counters with end
//                     pulses. Optional BCD outputs when TRAFFIC_BCD_EN is set.
// Revision          : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_countdown
    import traffic_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             ld_pd,
    input  logic [CNT_W-1:0] ld_val_pd,
    input  logic             ld_nopd,
    input  logic [CNT_W-1:0] ld_val_nopd,
    output logic             tick_1s,
    output logic             cnt_pd_end,
    output logic             cnt_nopd_end,
    output logic [CNT_W-1:0] remain_pd,
    output logic [CNT_W-1:0] remain_nopd
`ifdef TRAFFIC_BCD_EN
    ,
    output logic [7:0]       bcd_pd,
    output logic [7:0]       bcd_nopd
`endif
);

    logic               w_tick;
    logic [1:0]         w_ld;
    logic [2*CNT_W-1:0] w_ld_val;
    logic [2*CNT_W-1:0] w_cnt;
    logic [1:0]         w_end;

    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .tick_1s (w_tick)
    );

    assign w_ld     = {ld_nopd, ld_pd};
    assign w_ld_val = {ld_val_nopd, ld_val_pd};

    for (genvar i = 0; i < 2; i++) begin : g_chan
        logic [CNT_W-1:0] r_cnt;
        logic             r_end;
        logic [CNT_W-1:0] w_val;

        assign w_val = w_ld_val[i*CNT_W +: CNT_W];

        // Load wins over a same-cycle tick; a zero load still reports expiry
        // so the controlling FSM never waits forever.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cnt <= '0;
                r_end <= 1'b0;
            end else if (w_ld[i]) begin
                r_cnt <= w_val;
                r_end <= (w_val == '0);
            end else if (w_tick && run && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
                r_end <= (r_cnt == CNT_W'(1));
            end else begin
                r_end <= 1'b0;
            end
        end

        assign w_cnt[i*CNT_W +: CNT_W] = r_cnt;
        assign w_end[i]                = r_end;
    end

    assign tick_1s      = w_tick;
    assign cnt_pd_end   = w_end[0];
    assign cnt_nopd_end = w_end[1];
    assign remain_pd    = w_cnt[0 +: CNT_W];
    assign remain_nopd  = w_cnt[CNT_W +: CNT_W];

`ifdef TRAFFIC_BCD_EN
    logic [15:0] w_bcd;

    for (genvar j = 0; j < 2; j++) begin : g_bcd
        logic [7:0] r_bcd;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_bcd <= 8'h00;
            end else begin
                r_bcd <= to_bcd8(8'(w_cnt[j*CNT_W +: CNT_W]));
            end
        end

        assign w_bcd[j*8 +: 8] = r_bcd;
    end

    assign bcd_pd   = w_bcd[7:0];
    assign bcd_nopd = w_bcd[15:8];
`endif

endmodule

`default_nettype wire
